mesh_output_arbiter: RTL

MESH_OUTPUT_ARBITER -- requirements
Module: mesh_output_arbiter

---
 rtl/bsg_mesh_router_pkg.sv | 27 ++
 rtl/mesh_arb_starve_ctr.sv | 45 ++++
 rtl/mesh_output_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/bsg_mesh_router_pkg.sv
// Shared mesh-router definitions: direction indices, profiling stats record and
// small index helpers used by the output-port arbiters.
package bsg_mesh_router_pkg;

    typedef enum logic [2:0] {
        P  = 3'd0,
        W  = 3'd1,
        E  = 3'd2,
        N  = 3'd3,
        S  = 3'd4,
        RW = 3'd5,
        RE = 3'd6
    } bsg_mesh_dir_e;

    // Wide enough for the largest legal starvation limit (255).
    localparam int mesh_arb_wait_width_gp = 8;

    typedef struct packed {
        logic [31:0] grant_cnt;
        logic [31:0] stall_cnt;
    } mesh_arb_stat_s;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mesh_arb_starve_ctr.sv
// Per-input saturating wait counter; flags an input that has been passed over
// for starve_limit_p consecutive requesting cycles.
module mesh_arb_starve_ctr
    import bsg_mesh_router_pkg::*;
#(
    parameter int starve_limit_p = 15
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic req_i,
    input  logic yumi_i,
    output logic starved_o
);

    localparam logic [mesh_arb_wait_width_gp-1:0] limit_lp =
        mesh_arb_wait_width_gp'(starve_limit_p);

    logic [mesh_arb_wait_width_gp-1:0] wait_cnt_r;
    logic [mesh_arb_wait_width_gp-1:0] wait_cnt_n;
    logic                              starved_r;

    always_comb begin
        wait_cnt_n = wait_cnt_r;
        if (!req_i || yumi_i) begin
            wait_cnt_n = '0;
        end else if (wait_cnt_r < limit_lp) begin
            wait_cnt_n = wait_cnt_r + mesh_arb_wait_width_gp'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; reset is checked inside the clocked block (synchronous).
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wait_cnt_r <= '0;
            starved_r  <= 1'b0;
        end else begin
            wait_cnt_r <= wait_cnt_n;
            starved_r  <= (wait_cnt_n == limit_lp);
        end
    end

    assign starved_o = starved_r;

endmodule

// File: rtl/mesh_output_arbiter.sv
// One mesh output port: round-robin arbitration among dirs_lp inputs with a
// starvation override, combinational grant, and wrapping grant/stall counters.
module mesh_output_arbiter
    import bsg_mesh_router_pkg::*;
#(
    parameter int dims_p         = 2,
    parameter int starve_limit_p = 15,
    parameter int stat_width_p   = 32,
    localparam int dirs_lp       = 1 + 2 * dims_p
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [dirs_lp-1:0]      req_i,
    input  logic                    ready_i,
    output logic [dirs_lp-1:0]      yumi_o,
    output logic [dirs_lp-1:0]      sel_o,
    output logic                    v_o,
    output logic [dirs_lp-1:0]      starved_o,
    output logic [stat_width_p-1:0] grant_cnt_o,
    output logic [stat_width_p-1:0] stall_cnt_o
);

    localparam int ptr_width_lp = $clog2(dirs_lp);
    localparam logic [dirs_lp-1:0] sel_rst_lp = dirs_lp'(1) << int'(P);

    logic [ptr_width_lp-1:0] ptr_r;
    logic [ptr_width_lp-1:0] ptr_n;
    logic [ptr_width_lp-1:0] win_idx;
    logic [dirs_lp-1:0]      last_sel_r;
    logic [dirs_lp-1:0]      starved_req;
    logic [stat_width_p-1:0] grant_cnt_r;
    logic [stat_width_p-1:0] stall_cnt_r;
    logic                    any_req;
    logic                    grant;
    logic                    found;
    int                      idx;

    // NOTE: every always_comb output gets a default first so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        starved_req = req_i & starved_o;
        any_req     = |req_i;
        win_idx     = '0;
        found       = 1'b0;
        idx         = 0;
        if (|starved_req) begin
            // Scan downward so the lowest starved index is the last one written.
            for (int i = dirs_lp - 1; i >= 0; i--) begin
                if (starved_req[ptr_width_lp'(i)]) begin
                    win_idx = ptr_width_lp'(i);
                end
            end
        end else begin
            for (int off = 0; off < dirs_lp; off++) begin
                idx = (int'(ptr_r) + off) % dirs_lp;
                if (!found && req_i[ptr_width_lp'(idx)]) begin
                    win_idx = ptr_width_lp'(idx);
                    found   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant  = reset_n_i & ready_i & any_req;
        yumi_o = grant ? (dirs_lp'(1) << win_idx) : '0;
        v_o    = grant;
        sel_o  = grant ? yumi_o : last_sel_r;
        ptr_n  = grant ? ptr_width_lp'(wrap_inc(int'(win_idx), dirs_lp)) : ptr_r;
    end

    for (genvar i = 0; i < dirs_lp; i++) begin : g_starve
        mesh_arb_starve_ctr #(
            .starve_limit_p(starve_limit_p)
        ) u_starve_ctr (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .req_i    (req_i[i]),
            .yumi_i   (yumi_o[i]),
            .starved_o(starved_o[i])
        );
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            ptr_r       <= '0;
            last_sel_r  <= sel_rst_lp;
            grant_cnt_r <= '0;
            stall_cnt_r <= '0;
        end else begin
            ptr_r <= ptr_n;
            if (grant) begin
                last_sel_r  <= yumi_o;
                grant_cnt_r <= grant_cnt_r + stat_width_p'(1);
            end
            if (any_req && !ready_i) begin
                stall_cnt_r <= stall_cnt_r + stat_width_p'(1);
            end
        end
    end

    assign grant_cnt_o = grant_cnt_r;
    assign stall_cnt_o = stall_cnt_r;

endmodule
